// File: rtl/running_minmax.sv
// running_minmax
//   Streaming signed min/max tracker. Consumes a sample stream framed by
//   in_last and emits one result record per frame. The record holds the
//   smallest and largest sample, the index of the first occurrence of each,
//   and the sample count (saturating at 2^IDX_W-1, flagged by out_sat).
//   All data comparisons go through comparator_lt instances.
//
// Handshake semantics (both ports): a transfer happens on a rising clk edge
// where valid and ready are both high. valid, once raised by a producer, is
// not conditioned on ready. in_ready and out_valid are decoded only from
// registers, so no combinational path runs from any input to any output.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   in_valid     sample present
//   in_ready     block accepts a sample this cycle
//   in_data      signed sample, N bits
//   in_last      sample is the final one of its frame
//   out_valid    result record valid
//   out_ready    consumer takes the record
//   out_min      smallest sample of the frame
//   out_max      largest sample of the frame
//   out_min_idx  index of first occurrence of the minimum
//   out_max_idx  index of first occurrence of the maximum
//   out_count    samples in the frame (saturating)
//   out_sat      count saturated during the frame
//   dbg_state    current FSM state (S_IDLE=0, S_ACCUM=1, S_DONE=2)

// Signed strict less-than: lt = (a < b) treating both as two's complement.
module comparator_lt #(
  parameter int N = 32
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         lt
);
  assign lt = $signed(a) < $signed(b);
endmodule

module running_minmax #(
  parameter int N     = 32,
  parameter int IDX_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_min,
  output logic [N-1:0]     out_max,
  output logic [IDX_W-1:0] out_min_idx,
  output logic [IDX_W-1:0] out_max_idx,
  output logic [IDX_W-1:0] out_count,
  output logic             out_sat,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [IDX_W-1:0] CNT_MAX = '1;
  localparam logic [IDX_W-1:0] CNT_ONE = IDX_W'(1);

  state_t           r_state;
  state_t           w_state_nxt;

  // Low during reset and until the first edge after release, so that the
  // release of rst is synchronised before any sample can be accepted.
  logic             r_run;

  // Working accumulators for the frame in progress.
  logic [N-1:0]     r_min;
  logic [N-1:0]     r_max;
  logic [IDX_W-1:0] r_min_idx;
  logic [IDX_W-1:0] r_max_idx;
  logic [IDX_W-1:0] r_count;
  logic             r_sat;

  // Published record; holds the last completed frame until the next one.
  logic [N-1:0]     r_out_min;
  logic [N-1:0]     r_out_max;
  logic [IDX_W-1:0] r_out_min_idx;
  logic [IDX_W-1:0] r_out_max_idx;
  logic [IDX_W-1:0] r_out_count;
  logic             r_out_sat;

  logic [N-1:0]     w_min;
  logic [N-1:0]     w_max;
  logic [IDX_W-1:0] w_min_idx;
  logic [IDX_W-1:0] w_max_idx;
  logic [IDX_W-1:0] w_count;
  logic             w_sat;

  logic             w_accept;
  logic             w_load_out;
  logic             w_lt_min;
  logic             w_gt_max;

  comparator_lt #(.N(N)) u_cmp_min (
    .a  (in_data),
    .b  (r_min),
    .lt (w_lt_min)
  );

  comparator_lt #(.N(N)) u_cmp_max (
    .a  (r_max),
    .b  (in_data),
    .lt (w_gt_max)
  );

  assign in_ready   = r_run && (r_state != S_DONE);
  assign out_valid  = (r_state == S_DONE);
  assign w_accept   = in_valid && in_ready;
  assign w_load_out = w_accept && in_last;
  assign dbg_state  = r_state;

  always_comb begin
    w_state_nxt = r_state;
    w_min       = r_min;
    w_max       = r_max;
    w_min_idx   = r_min_idx;
    w_max_idx   = r_max_idx;
    w_count     = r_count;
    w_sat       = r_sat;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_min       = in_data;
          w_max       = in_data;
          w_min_idx   = '0;
          w_max_idx   = '0;
          w_count     = CNT_ONE;
          w_sat       = 1'b0;
          w_state_nxt = in_last ? S_DONE : S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (w_accept) begin
          // The index of this sample is the current count; once the count
          // saturates it stays at CNT_MAX, which clamps the index as well.
          if (w_lt_min) begin
            w_min     = in_data;
            w_min_idx = r_count;
          end
          if (w_gt_max) begin
            w_max     = in_data;
            w_max_idx = r_count;
          end
          if (r_count == CNT_MAX) begin
            w_sat = 1'b1;
          end else begin
            w_count = r_count + CNT_ONE;
          end
          if (in_last) begin
            w_state_nxt = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (out_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_run   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_run   <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_min     <= '0;
      r_max     <= '0;
      r_min_idx <= '0;
      r_max_idx <= '0;
      r_count   <= '0;
      r_sat     <= 1'b0;
    end else begin
      r_min     <= w_min;
      r_max     <= w_max;
      r_min_idx <= w_min_idx;
      r_max_idx <= w_max_idx;
      r_count   <= w_count;
      r_sat     <= w_sat;
    end
  end

  // The record is captured from the same next-values that finish the frame,
  // so out_valid and the record appear together one cycle after in_last.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out_min     <= '0;
      r_out_max     <= '0;
      r_out_min_idx <= '0;
      r_out_max_idx <= '0;
      r_out_count   <= '0;
      r_out_sat     <= 1'b0;
    end else if (w_load_out) begin
      r_out_min     <= w_min;
      r_out_max     <= w_max;
      r_out_min_idx <= w_min_idx;
      r_out_max_idx <= w_max_idx;
      r_out_count   <= w_count;
      r_out_sat     <= w_sat;
    end
  end

  assign out_min     = r_out_min;
  assign out_max     = r_out_max;
  assign out_min_idx = r_out_min_idx;
  assign out_max_idx = r_out_max_idx;
  assign out_count   = r_out_count;
  assign out_sat     = r_out_sat;

endmodule
